divergence_ctrl: RTL

//  Branch divergence/reconvergence sequencer for one 32-lane warp; sits directly upstream of the mask stack and drives its push/pop/mask inputs.

---
 rtl/divergence_ctrl_if.sv | 31 +++
 rtl/divergence_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/divergence_ctrl_if.sv
// Branch/fetch/mask-stack bundle between the warp front end and divergence_ctrl.
// master: upstream front end + mask stack; slave: divergence_ctrl.
interface divergence_ctrl_if #(
    parameter int PCW = 32
);
    logic           brValid;
    logic [31:0]    brTaken;
    logic [PCW-1:0] brTarget;
    logic [PCW-1:0] brFallthru;
    logic [PCW-1:0] brReconv;
    logic           pcValid;
    logic [PCW-1:0] pc;
    logic [31:0]    curMask;
    logic           pushEn;
    logic           popEn;
    logic [31:0]    inMask;
    logic           redirect;
    logic [PCW-1:0] redirectPc;
    logic           busy;
    logic           ovf;

    modport master (
        output brValid, brTaken, brTarget, brFallthru, brReconv, pcValid, pc, curMask,
        input  pushEn, popEn, inMask, redirect, redirectPc, busy, ovf
    );

    modport slave (
        input  brValid, brTaken, brTarget, brFallthru, brReconv, pcValid, pc, curMask,
        output pushEn, popEn, inMask, redirect, redirectPc, busy, ovf
    );
endinterface

// File: rtl/divergence_ctrl.sv
// Branch divergence/reconvergence sequencer for one 32-lane warp.
// Splits a resolved branch into taken/not-taken masks, pushes them onto the
// downstream mask stack, redirects fetch, and pops at reconvergence PCs.
// Optional: define DIV_PERF_CNT_EN to add divCount/uniCount counters.
module divergence_ctrl #(
    parameter int DEPTH = 16,
    parameter int PCW   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    divergence_ctrl_if.slave  bus
`ifdef DIV_PERF_CNT_EN
    ,
    output logic [31:0]       divCount,
    output logic [31:0]       uniCount
`endif
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [2:0] {IDLE, PUSH_N, PUSH_T, POP_T, POP_N} state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  lvl_q, lvl_d;
    logic           ovf_q, ovf_d;
    logic           pushEn_q, pushEn_d;
    logic           popEn_q, popEn_d;
    logic [31:0]    inMask_q, inMask_d;
    logic           redirect_q, redirect_d;
    logic [PCW-1:0] redirectPc_q, redirectPc_d;
    logic [31:0]    tMask_q, tMask_d;
    logic [PCW-1:0] tgt_q, tgt_d;

    // Reconvergence table; contents are only meaningful below lvl_q, so no reset.
    logic [PCW-1:0] reconv_q [DEPTH];
    logic [PCW-1:0] pend_q   [DEPTH];
    logic           phaseN_q [DEPTH];

    logic           tblWr, setN;
    logic [IW-1:0]  topIdx, wrIdx;
    logic [31:0]    tM, nM;
    logic           uniform, reconvHit;

    assign topIdx    = IW'(lvl_q - LW'(1));
    assign wrIdx     = IW'(lvl_q);
    assign tM        = bus.brTaken & bus.curMask;
    assign nM        = ~bus.brTaken & bus.curMask;
    // curMask==0 makes both halves empty and falls out as uniform not-taken.
    assign uniform   = (tM == '0) || (nM == '0);
    assign reconvHit = (state_q == IDLE) && bus.pcValid && (lvl_q != '0) &&
                       (bus.pc == reconv_q[topIdx]);

    assign bus.busy       = (state_q != IDLE) || reconvHit;
    assign bus.pushEn     = pushEn_q;
    assign bus.popEn      = popEn_q;
    assign bus.inMask     = inMask_q;
    assign bus.redirect   = redirect_q;
    assign bus.redirectPc = redirectPc_q;
    assign bus.ovf        = ovf_q;

    // Next state and next values of the registered strobes.
    always_comb begin
        state_d      = state_q;
        lvl_d        = lvl_q;
        ovf_d        = ovf_q;
        pushEn_d     = 1'b0;
        popEn_d      = 1'b0;
        inMask_d     = '0;
        redirect_d   = 1'b0;
        redirectPc_d = '0;
        tMask_d      = tMask_q;
        tgt_d        = tgt_q;
        tblWr        = 1'b0;
        setN         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (reconvHit) begin
                    popEn_d    = 1'b1;
                    redirect_d = 1'b1;
                    if (phaseN_q[topIdx]) begin
                        // Both paths done: drop the level, resume at reconv PC.
                        state_d      = POP_N;
                        lvl_d        = lvl_q - LW'(1);
                        redirectPc_d = reconv_q[topIdx];
                    end else begin
                        // Taken path done: expose not-taken mask, fetch its PC.
                        state_d      = POP_T;
                        setN         = 1'b1;
                        redirectPc_d = pend_q[topIdx];
                    end
                end else if (bus.brValid) begin
                    redirect_d = 1'b1;
                    if (uniform) begin
                        redirectPc_d = (tM != '0) ? bus.brTarget : bus.brFallthru;
                    end else if (lvl_q == DEPTH_L) begin
                        // Table full: every active lane follows the target, flagged.
                        ovf_d        = 1'b1;
                        redirectPc_d = bus.brTarget;
                    end else begin
                        redirect_d = 1'b0;
                        state_d    = PUSH_N;
                        tblWr      = 1'b1;
                        lvl_d      = lvl_q + LW'(1);
                        pushEn_d   = 1'b1;
                        inMask_d   = nM;
                        tMask_d    = tM;
                        tgt_d      = bus.brTarget;
                    end
                end
            end
            PUSH_N: begin
                state_d      = PUSH_T;
                pushEn_d     = 1'b1;
                inMask_d     = tMask_q;
                redirect_d   = 1'b1;
                redirectPc_d = tgt_q;
            end
            PUSH_T, POP_T, POP_N: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lvl_q        <= '0;
            ovf_q        <= 1'b0;
            pushEn_q     <= 1'b0;
            popEn_q      <= 1'b0;
            inMask_q     <= '0;
            redirect_q   <= 1'b0;
            redirectPc_q <= '0;
            tMask_q      <= '0;
            tgt_q        <= '0;
        end else begin
            state_q      <= state_d;
            lvl_q        <= lvl_d;
            ovf_q        <= ovf_d;
            pushEn_q     <= pushEn_d;
            popEn_q      <= popEn_d;
            inMask_q     <= inMask_d;
            redirect_q   <= redirect_d;
            redirectPc_q <= redirectPc_d;
            tMask_q      <= tMask_d;
            tgt_q        <= tgt_d;
        end
    end

    // Reconvergence table writes: new level on push, phase flip on taken-path pop.
    always_ff @(posedge clk) begin
        if (tblWr) begin
            reconv_q[wrIdx] <= bus.brReconv;
            pend_q[wrIdx]   <= bus.brFallthru;
            phaseN_q[wrIdx] <= 1'b0;
        end else if (setN) begin
            phaseN_q[topIdx] <= 1'b1;
        end
    end

`ifdef DIV_PERF_CNT_EN
    logic        divAcc, uniAcc;
    logic [31:0] divCnt_q, uniCnt_q;

    assign divAcc   = (state_q == IDLE) && (state_d == PUSH_N);
    assign uniAcc   = (state_q == IDLE) && !reconvHit && bus.brValid && uniform;
    assign divCount = divCnt_q;
    assign uniCount = uniCnt_q;

    // Accepted-branch counters, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divCnt_q <= '0;
            uniCnt_q <= '0;
        end else begin
            if (divAcc) divCnt_q <= divCnt_q + 32'd1;
            if (uniAcc) uniCnt_q <= uniCnt_q + 32'd1;
        end
    end
`endif
endmodule
